state_duration_checker: RTL and testbench
=========================================

STATE_DURATION_CHECKER -- requirements
Module: state_duration_checker

Interface
REQ-001 Parameter STATE_0_MIN_VAL, default 10, SHALL set the minimum legal low-run length in cycles, inclusive.
REQ-002 Parameter STATE_0_MAX_VAL, default 20, SHALL set the maximum legal low-run length in cycles, inclusive.
REQ-003 Parameter STATE_1_MIN_VAL, default 30, SHALL set the minimum legal high-run length in cycles, inclusive.
REQ-004 Parameter STATE_1_MAX_VAL, default 40, SHALL set the maximum legal high-run length in cycles, inclusive.
REQ-005 Parameter CNT_WIDTH, default 16, SHALL set the width of the run counter and of o_run_len.
REQ-006 i_clk, input, 1: the single clock; all logic SHALL be on its rising edge.
REQ-007 i_s_rst, input, 1: reset, synchronous and active-high.
REQ-008 i_state, input, 1: monitored level, e.g. a random two-state stimulus line.
REQ-009 o_run_valid, output, 1: one-cycle pulse, completed run reported.
REQ-010 o_run_level, output, 1: level of the reported run; valid with o_run_valid.
REQ-011 o_run_len, output, CNT_WIDTH: length of the reported run in cycles; valid with o_run_valid.
REQ-012 o_err, output, 1: one-cycle pulse, run-length violation.
REQ-013 o_err_code, output, 2: 01 = too short, 10 = too long; valid with o_err.
REQ-014 o_err_sticky, output, 1: set on the first o_err; cleared only by reset.
REQ-015 o_err_cnt, output, CNT_WIDTH: saturating count of o_err pulses.

Function
REQ-016 The block SHALL register i_state into s_prev every cycle; an edge is a cycle where i_state != s_prev.
REQ-017 The FSM SHALL have states SYNC, RUN0 and RUN1; reset enters SYNC.
REQ-018 In SYNC, the first run is partial, so it SHALL be neither measured nor reported.
REQ-019 On the first edge in SYNC, the FSM SHALL go to RUN0 if i_state=0, or RUN1 if i_state=1, and load cnt=1.
REQ-020 In RUNx with no edge, cnt SHALL increment, saturating at 2^CNT_WIDTH-1.
REQ-021 On an edge in RUNx, the cycle after the edge SHALL show:
- o_run_valid=1
- o_run_level=x
- o_run_len=cnt, the count before reload

cnt SHALL reload to 1, and the FSM SHALL switch to the other RUN state.
REQ-022 On an edge with cnt < MIN(x), o_err SHALL pulse the following cycle with o_err_code=01, coincident with o_run_valid.
REQ-023 Too-long detection: in RUNx with no edge, when cnt+1 first exceeds MAX(x), o_err SHALL pulse the following cycle with o_err_code=10, without waiting for the run to end.
REQ-024 Too-long SHALL be flagged at most once per run; the eventual edge of that run SHALL report the run with no second error.
REQ-025 Runs with MIN(x) <= length <= MAX(x) SHALL produce no error.
REQ-026 A saturated cnt SHALL report o_run_len=2^CNT_WIDTH-1.
REQ-027 Reporting latency SHALL be exactly 1 cycle after the edge cycle.
REQ-028 Back-to-back edges SHALL each report a run of length 1.
REQ-029 Parameters with MIN > MAX for either level SHALL raise an elaboration-time error.

Reset
REQ-030 While i_s_rst=1, every output SHALL be 0, along with s_prev, cnt and the too-long flag, and the FSM SHALL be in SYNC.
REQ-031 Reset asserted mid-run SHALL discard that run without any report or error; after release, the block SHALL resynchronise per REQ-019.

Configuration
REQ-032 Macro STATE_DURATION_CHECKER_ERR_CNT_EN SHALL control the error counter:
- Defined: o_err_cnt SHALL be implemented per REQ-015.
- Undefined: o_err_cnt SHALL be constant 0 with no counter logic; all other behaviour is unchanged.

Verification (default parameters)
REQ-033 Reset, then low 5 cycles, then high 35, low 15, high 1 -> first run unreported; reports (1,35) then (0,15); no o_err.
REQ-034 In RUN0, low held 8 cycles then high -> o_run_len=8, o_run_level=0, o_err=1 with code 01, same cycle; o_err_sticky stays 1.
REQ-035 In RUN1, high held 50 cycles -> o_err code 10 exactly 1 cycle after the 41st high cycle (cnt+1=41 > 40); at the edge, report (1,50) with no second o_err.
REQ-036 Input toggling every cycle after sync -> o_run_valid every cycle with o_run_len=1, plus a too-short o_err each cycle; o_err_cnt saturates when the macro is defined and stays 0 when it is not.
REQ-037 Reset asserted at cycle 20 of a high run, released 3 cycles later -> all outputs 0, no report, SYNC re-entered.

Source files
------------

// File: rtl/state_duration_checker_if.sv
// Bundles the monitored level and all report/error outputs of state_duration_checker.
// The slave modport is the checker side; master is the stimulus/consumer side.
interface state_duration_checker_if #(
   parameter int unsigned CNT_WIDTH = 16
);
   logic                 i_state;
   logic                 o_run_valid;
   logic                 o_run_level;
   logic [CNT_WIDTH-1:0] o_run_len;
   logic                 o_err;
   logic [1:0]           o_err_code;
   logic                 o_err_sticky;
   logic [CNT_WIDTH-1:0] o_err_cnt;

   modport master (
      output i_state,
      input  o_run_valid, o_run_level, o_run_len,
      input  o_err, o_err_code, o_err_sticky, o_err_cnt
   );

   modport slave (
      input  i_state,
      output o_run_valid, o_run_level, o_run_len,
      output o_err, o_err_code, o_err_sticky, o_err_cnt
   );
endinterface

// File: rtl/state_duration_checker.sv
// Measures low/high run lengths of i_state, reports each completed run and flags too-short/too-long runs.
// Optional saturating error counter enabled by macro STATE_DURATION_CHECKER_ERR_CNT_EN.
module state_duration_checker #(
   parameter int unsigned STATE_0_MIN_VAL = 10,
   parameter int unsigned STATE_0_MAX_VAL = 20,
   parameter int unsigned STATE_1_MIN_VAL = 30,
   parameter int unsigned STATE_1_MAX_VAL = 40,
   parameter int unsigned CNT_WIDTH       = 16
) (
   input  logic                    i_clk,
   input  logic                    i_s_rst,
   state_duration_checker_if.slave bus_if
);

   if (STATE_0_MIN_VAL > STATE_0_MAX_VAL) begin : g_bad_state0_limits
      $error("state_duration_checker: STATE_0_MIN_VAL exceeds STATE_0_MAX_VAL");
   end
   if (STATE_1_MIN_VAL > STATE_1_MAX_VAL) begin : g_bad_state1_limits
      $error("state_duration_checker: STATE_1_MIN_VAL exceeds STATE_1_MAX_VAL");
   end

   typedef enum logic [1:0] {ST_SYNC, ST_RUN0, ST_RUN1} state_t;

   localparam logic [1:0] CODE_SHORT = 2'b01;
   localparam logic [1:0] CODE_LONG  = 2'b10;

   // Limits widened by one bit so cnt+1 can be compared without wrapping.
   localparam logic [CNT_WIDTH:0] MIN0 = (CNT_WIDTH+1)'(STATE_0_MIN_VAL);
   localparam logic [CNT_WIDTH:0] MAX0 = (CNT_WIDTH+1)'(STATE_0_MAX_VAL);
   localparam logic [CNT_WIDTH:0] MIN1 = (CNT_WIDTH+1)'(STATE_1_MIN_VAL);
   localparam logic [CNT_WIDTH:0] MAX1 = (CNT_WIDTH+1)'(STATE_1_MAX_VAL);

   state_t               r_state, w_state_nxt;
   logic                 r_s_prev;
   logic [CNT_WIDTH-1:0] r_cnt, w_cnt_nxt;
   logic                 r_long, w_long_nxt;
   logic                 r_run_valid, w_run_valid_nxt;
   logic                 r_run_level, w_run_level_nxt;
   logic [CNT_WIDTH-1:0] r_run_len, w_run_len_nxt;
   logic                 r_err, w_err_nxt;
   logic [1:0]           r_err_code, w_err_code_nxt;
   logic                 r_err_sticky;

   logic                 w_edge;
   logic [CNT_WIDTH:0]   w_cnt_inc;
   logic [CNT_WIDTH:0]   w_min;
   logic [CNT_WIDTH:0]   w_max;

   assign w_edge    = bus_if.i_state != r_s_prev;
   assign w_cnt_inc = {1'b0, r_cnt} + 1'b1;
   assign w_min     = (r_state == ST_RUN1) ? MIN1 : MIN0;
   assign w_max     = (r_state == ST_RUN1) ? MAX1 : MAX0;

   // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
   always_comb begin
      w_state_nxt     = r_state;
      w_cnt_nxt       = r_cnt;
      w_long_nxt      = r_long;
      w_run_valid_nxt = 1'b0;
      w_run_level_nxt = 1'b0;
      w_run_len_nxt   = '0;
      w_err_nxt       = 1'b0;
      w_err_code_nxt  = 2'b00;

      case (r_state)
         ST_SYNC: begin
            if (w_edge) begin
               w_state_nxt = bus_if.i_state ? ST_RUN1 : ST_RUN0;
               w_cnt_nxt   = CNT_WIDTH'(1);
               w_long_nxt  = 1'b0;
            end
         end
         ST_RUN0, ST_RUN1: begin
            if (w_edge) begin
               w_run_valid_nxt = 1'b1;
               w_run_level_nxt = (r_state == ST_RUN1);
               w_run_len_nxt   = r_cnt;
               if ({1'b0, r_cnt} < w_min) begin
                  w_err_nxt      = 1'b1;
                  w_err_code_nxt = CODE_SHORT;
               end
               w_cnt_nxt   = CNT_WIDTH'(1);
               w_long_nxt  = 1'b0;
               w_state_nxt = (r_state == ST_RUN1) ? ST_RUN0 : ST_RUN1;
            end else begin
               w_cnt_nxt = w_cnt_inc[CNT_WIDTH] ? r_cnt : w_cnt_inc[CNT_WIDTH-1:0];
               // A long run is flagged once, as soon as it overshoots, not at its end.
               if (!r_long && (w_cnt_inc > w_max)) begin
                  w_err_nxt      = 1'b1;
                  w_err_code_nxt = CODE_LONG;
                  w_long_nxt     = 1'b1;
               end
            end
         end
         default: w_state_nxt = ST_SYNC;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge i_clk) begin
      if (i_s_rst) begin
         r_state      <= ST_SYNC;
         r_s_prev     <= 1'b0;
         r_cnt        <= '0;
         r_long       <= 1'b0;
         r_run_valid  <= 1'b0;
         r_run_level  <= 1'b0;
         r_run_len    <= '0;
         r_err        <= 1'b0;
         r_err_code   <= 2'b00;
         r_err_sticky <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_s_prev     <= bus_if.i_state;
         r_cnt        <= w_cnt_nxt;
         r_long       <= w_long_nxt;
         r_run_valid  <= w_run_valid_nxt;
         r_run_level  <= w_run_level_nxt;
         r_run_len    <= w_run_len_nxt;
         r_err        <= w_err_nxt;
         r_err_code   <= w_err_code_nxt;
         r_err_sticky <= r_err_sticky | w_err_nxt;
      end
   end

`ifdef STATE_DURATION_CHECKER_ERR_CNT_EN
   logic [CNT_WIDTH-1:0] r_err_cnt;

   always_ff @(posedge i_clk) begin
      if (i_s_rst) begin
         r_err_cnt <= '0;
      end else if (w_err_nxt && (r_err_cnt != {CNT_WIDTH{1'b1}})) begin
         r_err_cnt <= r_err_cnt + 1'b1;
      end
   end

   assign bus_if.o_err_cnt = r_err_cnt;
`else
   assign bus_if.o_err_cnt = '0;
`endif

   assign bus_if.o_run_valid  = r_run_valid;
   assign bus_if.o_run_level  = r_run_level;
   assign bus_if.o_run_len    = r_run_len;
   assign bus_if.o_err        = r_err;
   assign bus_if.o_err_code   = r_err_code;
   assign bus_if.o_err_sticky = r_err_sticky;

endmodule

// File: tb/tb_state_duration_checker.sv
// Self-checking bench for state_duration_checker: table of run segments plus directed long-run,
// toggle, saturation and mid-run reset sequences. Narrow CNT_WIDTH keeps saturation reachable.
module tb_state_duration_checker;

   localparam int CW      = 8;
   localparam int MIN0    = 10;
   localparam int MAX0    = 20;
   localparam int MIN1    = 30;
   localparam int MAX1    = 40;
   localparam int SAT     = (1 << CW) - 1;
   localparam int OW      = 2 * CW + 6;

   typedef logic [OW-1:0] obs_t;

   typedef struct {
      string      name;
      logic       rst;
      logic       lvl;
      int         n;
      logic       v;
      logic       l;
      int         len;
      logic       e;
      logic [1:0] code;
   } seg_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   state_duration_checker_if #(.CNT_WIDTH(CW)) sif ();

   state_duration_checker #(
      .STATE_0_MIN_VAL (MIN0),
      .STATE_0_MAX_VAL (MAX0),
      .STATE_1_MIN_VAL (MIN1),
      .STATE_1_MAX_VAL (MAX1),
      .CNT_WIDTH       (CW)
   ) dut (
      .i_clk   (clk),
      .i_s_rst (rst),
      .bus_if  (sif.slave)
   );

   int   n_checks   = 0;
   int   n_errors   = 0;
   int   exp_errs   = 0;
   logic exp_sticky = 1'b0;

   function automatic obs_t pack(input logic v, input logic l, input int len, input logic e,
                                 input logic [1:0] code, input logic st, input int ec);
      return {v, l, CW'(len), e, code, st, CW'(ec)};
   endfunction

   function automatic int exp_cnt();
`ifdef STATE_DURATION_CHECKER_ERR_CNT_EN
      return (exp_errs > SAT) ? SAT : exp_errs;
`else
      return 0;
`endif
   endfunction

   task automatic check(input string name, input obs_t act, input obs_t exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %h expected %h (valid,level,len,err,code,sticky,err_cnt)",
                  name, $time, act, exp);
      end
   endtask

   task automatic step(input logic r, input logic lvl);
      rst         = r;
      sif.i_state = lvl;
      @(posedge clk);
      #1;
   endtask

   task automatic check_report(input string name, input logic v, input logic l, input int len,
                               input logic e, input logic [1:0] code);
      obs_t act;
      if (e) begin
         exp_errs++;
         exp_sticky = 1'b1;
      end
      act = {sif.o_run_valid, sif.o_run_level, sif.o_run_len, sif.o_err, sif.o_err_code,
             sif.o_err_sticky, sif.o_err_cnt};
      check(name, act, pack(v, l, len, e, code, exp_sticky, exp_cnt()));
   endtask

   // Holds lvl for cycles 2..n of a run; a too-long error is expected only on cycle err_at.
   task automatic hold(input string name, input logic lvl, input int n, input int err_at);
      for (int i = 2; i <= n; i++) begin
         step(1'b0, lvl);
         check_report(name, 1'b0, 1'b0, 0, (i == err_at), (i == err_at) ? 2'b10 : 2'b00);
      end
   endtask

   task automatic reset_cycle(input string name, input logic lvl);
      exp_errs   = 0;
      exp_sticky = 1'b0;
      step(1'b1, lvl);
      check_report(name, 1'b0, 1'b0, 0, 1'b0, 2'b00);
   endtask

   seg_t segs[14];
   logic lvl;

   initial begin
      segs[0]  = '{"reset",        1'b1, 1'b0, 3,  1'b0, 1'b0, 0,  1'b0, 2'b00};
      segs[1]  = '{"sync_low",     1'b0, 1'b0, 5,  1'b0, 1'b0, 0,  1'b0, 2'b00};
      segs[2]  = '{"first_edge",   1'b0, 1'b1, 35, 1'b0, 1'b0, 0,  1'b0, 2'b00};
      segs[3]  = '{"rep_h35",      1'b0, 1'b0, 15, 1'b1, 1'b1, 35, 1'b0, 2'b00};
      segs[4]  = '{"rep_l15",      1'b0, 1'b1, 1,  1'b1, 1'b0, 15, 1'b0, 2'b00};
      segs[5]  = '{"rep_h1_short", 1'b0, 1'b0, 8,  1'b1, 1'b1, 1,  1'b1, 2'b01};
      segs[6]  = '{"rep_l8_short", 1'b0, 1'b1, 35, 1'b1, 1'b0, 8,  1'b1, 2'b01};
      segs[7]  = '{"rep_h35_b",    1'b0, 1'b0, 10, 1'b1, 1'b1, 35, 1'b0, 2'b00};
      segs[8]  = '{"rep_l10_min",  1'b0, 1'b1, 30, 1'b1, 1'b0, 10, 1'b0, 2'b00};
      segs[9]  = '{"rep_h30_min",  1'b0, 1'b0, 20, 1'b1, 1'b1, 30, 1'b0, 2'b00};
      segs[10] = '{"rep_l20_max",  1'b0, 1'b1, 40, 1'b1, 1'b0, 20, 1'b0, 2'b00};
      segs[11] = '{"rep_h40_max",  1'b0, 1'b0, 9,  1'b1, 1'b1, 40, 1'b0, 2'b00};
      segs[12] = '{"rep_l9_short", 1'b0, 1'b1, 29, 1'b1, 1'b0, 9,  1'b1, 2'b01};
      segs[13] = '{"rep_h29_short",1'b0, 1'b0, 11, 1'b1, 1'b1, 29, 1'b1, 2'b01};

      sif.i_state = 1'b0;
      #2;

      // Each segment: first cycle shows the report of the previous run, the rest must stay quiet.
      for (int s = 0; s < 14; s++) begin
         if (segs[s].rst) begin
            for (int i = 0; i < segs[s].n; i++) reset_cycle(segs[s].name, segs[s].lvl);
         end else begin
            step(1'b0, segs[s].lvl);
            check_report(segs[s].name, segs[s].v, segs[s].l, segs[s].len, segs[s].e, segs[s].code);
            hold(segs[s].name, segs[s].lvl, segs[s].n, 0);
         end
      end

      // High run of 50: too-long fires right after the 41st high cycle, end reports once.
      step(1'b0, 1'b1);
      check_report("rep_l11", 1'b1, 1'b0, 11, 1'b0, 2'b00);
      hold("long_h", 1'b1, 50, MAX1 + 1);
      step(1'b0, 1'b0);
      check_report("rep_h50_no2nd", 1'b1, 1'b1, 50, 1'b0, 2'b00);
      hold("long_l", 1'b0, 25, MAX0 + 1);

      // Toggling every cycle: length-1 runs, each too short.
      step(1'b0, 1'b1);
      check_report("rep_l25_no2nd", 1'b1, 1'b0, 25, 1'b0, 2'b00);
      lvl = 1'b1;
      for (int k = 0; k < 300; k++) begin
         lvl = ~lvl;
         step(1'b0, lvl);
         check_report("toggle", 1'b1, ~lvl, 1, 1'b1, 2'b01);
      end

      // Low run longer than the counter range: length saturates.
      step(1'b0, 1'b0);
      check_report("rep_toggle_last", 1'b1, 1'b1, 1, 1'b1, 2'b01);
      hold("sat_l", 1'b0, 300, MAX0 + 1);
      step(1'b0, 1'b1);
      check_report("rep_sat", 1'b1, 1'b0, SAT, 1'b0, 2'b00);

      // Reset in the middle of a high run, then resynchronise from a low level.
      hold("pre_rst", 1'b1, 20, 0);
      for (int i = 0; i < 3; i++) reset_cycle("mid_rst", 1'b1);
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 1'b0);
         check_report("post_rst_sync", 1'b0, 1'b0, 0, 1'b0, 2'b00);
      end
      step(1'b0, 1'b1);
      check_report("resync_edge", 1'b0, 1'b0, 0, 1'b0, 2'b00);
      hold("resync_h", 1'b1, 31, 0);
      step(1'b0, 1'b0);
      check_report("rep_resync_h31", 1'b1, 1'b1, 31, 1'b0, 2'b00);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
